// File: rtl/game_ctrl_if.sv
// Bundle of the game controller's button, map-state and status signals.
// Combinational wires only; no latency of its own.
// No backpressure: every signal is a one-cycle pulse or a level.
interface game_ctrl_if;
    logic        btn_start;
    logic        btn_sel_in;
    logic [3:0]  btn_mv_in;
    logic [2:0]  cursor_X;
    logic [2:0]  cursor_Y;
    logic [63:0] mine_flat;
    logic [5:0]  num_clicked;
    logic        load_new_map;
    logic        btn_sel_out;
    logic [3:0]  btn_mv_out;
    logic [2:0]  game_state;
    logic [9:0]  elapsed_sec;

    // Stimulus / map-state side
    modport master (
        output btn_start, btn_sel_in, btn_mv_in, cursor_X, cursor_Y,
               mine_flat, num_clicked,
        input  load_new_map, btn_sel_out, btn_mv_out, game_state, elapsed_sec
    );

    // Controller side
    modport slave (
        input  btn_start, btn_sel_in, btn_mv_in, cursor_X, cursor_Y,
               mine_flat, num_clicked,
        output load_new_map, btn_sel_out, btn_mv_out, game_state, elapsed_sec
    );
endinterface

// File: rtl/game_ctrl.sv
// Minesweeper game FSM: gates buttons to map state, judges selects, runs play timer (GAME_TIMER_EN).
// State changes one cycle after a button pulse; sel/mv gating is combinational (zero latency).
// No backpressure: pulses outside PLAY are dropped; btn_start always wins.
module game_ctrl #(
    parameter int NUM_MINES     = 10,
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    game_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    // Revealing this many squares means every safe square is open.
    localparam logic [5:0] WIN_COUNT = 6'(64 - NUM_MINES);

    state_t state;
    state_t state_nxt;
    logic   load_q;
    logic   mine_hit;

    // Parameters outside the legal range make the win count or timer meaningless.
    if (NUM_MINES < 1 || NUM_MINES > 63 || TICKS_PER_SEC < 2) begin : g_bad_param
        $error("game_ctrl: NUM_MINES must be 1..63 and TICKS_PER_SEC >= 2");
    end

    assign mine_hit = bus.mine_flat[{bus.cursor_X, bus.cursor_Y}];

    // Next-state decision; btn_start overrides everything, including IDLE/WIN/LOSE.
    always_comb begin
        state_nxt = state;
        if (bus.btn_start) begin
            state_nxt = CLEAR;
        end else begin
            case (state)
                CLEAR:   state_nxt = PLAY;
                PLAY:    if (bus.btn_sel_in) state_nxt = CHECK;
                CHECK: begin
                    if (mine_hit)                           state_nxt = LOSE;
                    else if (bus.num_clicked == WIN_COUNT)  state_nxt = WIN;
                    else                                    state_nxt = PLAY;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // State register with a registered CLEAR flag so load_new_map is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            load_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            load_q <= (state_nxt == CLEAR);
        end
    end

    assign bus.game_state   = state;
    assign bus.load_new_map = load_q;
    // A select coinciding with btn_start is dropped: the board is about to be wiped.
    assign bus.btn_sel_out  = (state == PLAY) && !bus.btn_start && bus.btn_sel_in;
    assign bus.btn_mv_out   = (state == PLAY) ? bus.btn_mv_in : 4'd0;

`ifdef GAME_TIMER_EN
    localparam int             PRE_W     = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [9:0]     SEC_MAX   = 10'd999;

    logic [PRE_W-1:0] prescaler;
    logic [9:0]       elapsed_q;

    // Seconds counter: runs only while the player is active, restarts on a new game.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            elapsed_q <= '0;
        end else if (state == CLEAR) begin
            prescaler <= '0;
            elapsed_q <= '0;
        end else if (state == PLAY || state == CHECK) begin
            if (prescaler == TICK_LAST) begin
                prescaler <= '0;
                if (elapsed_q != SEC_MAX) elapsed_q <= elapsed_q + 10'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    assign bus.elapsed_sec = elapsed_q;
`else
    assign bus.elapsed_sec = 10'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: vector table, corner sequences, randomized run vs model.
// Inputs change on the falling edge; outputs are sampled shortly after it.
// Bounded: every phase runs a fixed number of cycles.
module tb_game_ctrl;
    localparam int NM  = 10;
    localparam int TPS = 4;

    localparam int S_IDLE = 0, S_CLEAR = 1, S_PLAY = 2, S_CHECK = 3, S_WIN = 4, S_LOSE = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_ctrl_if bus();

    game_ctrl #(.NUM_MINES(NM), .TICKS_PER_SEC(TPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: game phase code plus cycles spent active since the last CLEAR.
    int m_st  = S_IDLE;
    int m_cnt = 0;

    typedef struct {
        logic        start;
        logic        sel;
        logic [3:0]  mv;
        logic [2:0]  cx;
        logic [2:0]  cy;
        logic [63:0] mine;
        logic [5:0]  clicked;
        logic [2:0]  e_now;
        logic        e_load;
        logic        e_sel;
        logic [3:0]  e_mv;
        logic [2:0]  e_next;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int m_elapsed();
`ifdef GAME_TIMER_EN
        return (m_cnt / TPS > 999) ? 999 : m_cnt / TPS;
`else
        return 0;
`endif
    endfunction

    task automatic check_model();
        check("model_state", 64'(bus.game_state), 64'(m_st));
        check("model_load", 64'(bus.load_new_map), 64'(m_st == S_CLEAR));
        check("model_mv_out", 64'(bus.btn_mv_out), (m_st == S_PLAY) ? 64'(bus.btn_mv_in) : 64'd0);
        check("model_sel_out", 64'(bus.btn_sel_out),
              64'(m_st == S_PLAY && !bus.btn_start && bus.btn_sel_in));
        check("model_elapsed", 64'(bus.elapsed_sec), 64'(m_elapsed()));
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        int idx;
        idx = int'(bus.cursor_X) * 8 + int'(bus.cursor_Y);
        if (m_st == S_PLAY || m_st == S_CHECK) m_cnt++;
        else if (m_st == S_CLEAR) m_cnt = 0;
        if (bus.btn_start) m_st = S_CLEAR;
        else begin
            case (m_st)
                S_CLEAR: m_st = S_PLAY;
                S_PLAY:  if (bus.btn_sel_in) m_st = S_CHECK;
                S_CHECK: begin
                    if (bus.mine_flat[idx])                  m_st = S_LOSE;
                    else if (int'(bus.num_clicked) == 64 - NM) m_st = S_WIN;
                    else                                     m_st = S_PLAY;
                end
                default: ;
            endcase
        end
    endtask

    task automatic set_in(input logic start, input logic sel, input logic [3:0] mv,
                          input logic [2:0] cx, input logic [2:0] cy,
                          input logic [63:0] mine, input logic [5:0] clicked);
        bus.btn_start   = start;
        bus.btn_sel_in  = sel;
        bus.btn_mv_in   = mv;
        bus.cursor_X    = cx;
        bus.cursor_Y    = cy;
        bus.mine_flat   = mine;
        bus.num_clicked = clicked;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    logic [63:0] mine_m;
    logic [63:0] rmine;

    initial begin
        mine_m = 64'd1 << 21;

        //          st sel mv     cx    cy    mine    clk    now load sel mv   next
        vecs[0]  = '{1'b0,1'b1,4'h8,3'd2,3'd5,mine_m,6'd0, 3'd0,1'b0,1'b0,4'h0,3'd0};
        vecs[1]  = '{1'b1,1'b0,4'h0,3'd2,3'd5,mine_m,6'd0, 3'd0,1'b0,1'b0,4'h0,3'd1};
        vecs[2]  = '{1'b0,1'b0,4'h0,3'd2,3'd5,mine_m,6'd0, 3'd1,1'b1,1'b0,4'h0,3'd2};
        vecs[3]  = '{1'b0,1'b0,4'h4,3'd2,3'd5,mine_m,6'd0, 3'd2,1'b0,1'b0,4'h4,3'd2};
        vecs[4]  = '{1'b0,1'b1,4'h1,3'd2,3'd5,mine_m,6'd0, 3'd2,1'b0,1'b1,4'h1,3'd3};
        vecs[5]  = '{1'b0,1'b1,4'h8,3'd2,3'd5,mine_m,6'd0, 3'd3,1'b0,1'b0,4'h0,3'd5};
        vecs[6]  = '{1'b0,1'b1,4'h8,3'd2,3'd5,mine_m,6'd0, 3'd5,1'b0,1'b0,4'h0,3'd5};
        vecs[7]  = '{1'b1,1'b0,4'h0,3'd2,3'd5,mine_m,6'd0, 3'd5,1'b0,1'b0,4'h0,3'd1};
        vecs[8]  = '{1'b0,1'b0,4'h0,3'd2,3'd5,mine_m,6'd0, 3'd1,1'b1,1'b0,4'h0,3'd2};
        vecs[9]  = '{1'b0,1'b1,4'h0,3'd0,3'd0,mine_m,6'd53,3'd2,1'b0,1'b1,4'h0,3'd3};
        vecs[10] = '{1'b0,1'b0,4'h0,3'd0,3'd0,mine_m,6'd53,3'd3,1'b0,1'b0,4'h0,3'd2};
        vecs[11] = '{1'b0,1'b1,4'h0,3'd0,3'd0,mine_m,6'd54,3'd2,1'b0,1'b1,4'h0,3'd3};
        vecs[12] = '{1'b0,1'b0,4'h0,3'd0,3'd0,mine_m,6'd54,3'd3,1'b0,1'b0,4'h0,3'd4};
        vecs[13] = '{1'b0,1'b1,4'hf,3'd2,3'd5,mine_m,6'd54,3'd4,1'b0,1'b0,4'h0,3'd4};
        vecs[14] = '{1'b1,1'b1,4'h0,3'd2,3'd5,mine_m,6'd54,3'd4,1'b0,1'b0,4'h0,3'd1};
        vecs[15] = '{1'b0,1'b0,4'h0,3'd2,3'd5,mine_m,6'd0, 3'd1,1'b1,1'b0,4'h0,3'd2};
        vecs[16] = '{1'b1,1'b1,4'h2,3'd2,3'd5,mine_m,6'd0, 3'd2,1'b0,1'b0,4'h2,3'd1};
        vecs[17] = '{1'b0,1'b0,4'h0,3'd2,3'd5,mine_m,6'd0, 3'd1,1'b1,1'b0,4'h0,3'd2};

        // Reset: outputs quiet even with buttons pressed while rst is high.
        rst = 1'b1;
        set_in(1'b1, 1'b1, 4'hf, 3'd2, 3'd5, mine_m, 6'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", 64'(bus.game_state), 64'd0);
        check("rst_load", 64'(bus.load_new_map), 64'd0);
        check("rst_sel_out", 64'(bus.btn_sel_out), 64'd0);
        check("rst_mv_out", 64'(bus.btn_mv_out), 64'd0);
        check("rst_elapsed", 64'(bus.elapsed_sec), 64'd0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 64'd0, 6'd0);
        rst = 1'b0;
        m_st = S_IDLE;
        m_cnt = 0;

        // Vector table.
        for (int i = 0; i < 18; i++) begin
            set_in(vecs[i].start, vecs[i].sel, vecs[i].mv, vecs[i].cx, vecs[i].cy,
                   vecs[i].mine, vecs[i].clicked);
            #1;
            check($sformatf("vec%0d_state", i), 64'(bus.game_state), 64'(vecs[i].e_now));
            check($sformatf("vec%0d_load", i), 64'(bus.load_new_map), 64'(vecs[i].e_load));
            check($sformatf("vec%0d_sel_out", i), 64'(bus.btn_sel_out), 64'(vecs[i].e_sel));
            check($sformatf("vec%0d_mv_out", i), 64'(bus.btn_mv_out), 64'(vecs[i].e_mv));
            cycle();
            check($sformatf("vec%0d_next", i), 64'(bus.game_state), 64'(vecs[i].e_next));
        end

        // Timer: long play run saturates, new game clears it.
        set_in(1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 64'd0, 6'd0);
        cycle();
        set_in(1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 64'd0, 6'd0);
        cycle();
        for (int i = 0; i < 4003; i++) begin
            bus.btn_mv_in = 4'($urandom);
            cycle();
        end
`ifdef GAME_TIMER_EN
        check("timer_saturated", 64'(bus.elapsed_sec), 64'd999);
`else
        check("timer_disabled", 64'(bus.elapsed_sec), 64'd0);
`endif
        check("timer_still_play", 64'(bus.game_state), 64'd2);
        set_in(1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 64'd0, 6'd0);
        cycle();
        set_in(1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 64'd0, 6'd0);
        cycle();
        check("timer_cleared", 64'(bus.elapsed_sec), 64'd0);
        check("timer_restart_play", 64'(bus.game_state), 64'd2);

        // Asynchronous reset while judging a select.
        set_in(1'b0, 1'b1, 4'h0, 3'd1, 3'd1, 64'd0, 6'd3);
        cycle();
        set_in(1'b0, 1'b1, 4'hf, 3'd1, 3'd1, 64'd0, 6'd3);
        #1;
        check("pre_rst_check", 64'(bus.game_state), 64'd3);
        rst = 1'b1;
        #1;
        check("async_rst_state", 64'(bus.game_state), 64'd0);
        check("async_rst_load", 64'(bus.load_new_map), 64'd0);
        check("async_rst_sel", 64'(bus.btn_sel_out), 64'd0);
        check("async_rst_mv", 64'(bus.btn_mv_out), 64'd0);
        check("async_rst_elapsed", 64'(bus.elapsed_sec), 64'd0);
        m_st = S_IDLE;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.btn_sel_in = 1'b1;
            bus.btn_mv_in  = 4'($urandom);
            cycle();
        end
        check("post_rst_idle", 64'(bus.game_state), 64'd0);
        set_in(1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 64'd0, 6'd0);
        cycle();
        check("post_rst_clear", 64'(bus.load_new_map), 64'd1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            rmine = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
            case ($urandom_range(0, 2))
                0:       bus.num_clicked = 6'd53;
                1:       bus.num_clicked = 6'd54;
                default: bus.num_clicked = 6'($urandom);
            endcase
            bus.btn_start  = ($urandom_range(0, 39) == 0);
            bus.btn_sel_in = ($urandom_range(0, 3) == 0);
            bus.btn_mv_in  = 4'($urandom);
            bus.cursor_X   = 3'($urandom);
            bus.cursor_Y   = 3'($urandom);
            bus.mine_flat  = rmine;
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
